// File: rtl/thumb_fetch_align_pkg.sv
// Shared Thumb-2 fetch definitions: halfword width, 32-bit prefix codes,
// the prefix-match helper (also used by inst_pattern_match) and fetch FSM states.
package thumb_fetch_align_pkg;

  localparam int unsigned HW_W = 16;

  localparam logic [4:0] T32_PFX_A = 5'b11101;
  localparam logic [4:0] T32_PFX_B = 5'b11110;
  localparam logic [4:0] T32_PFX_C = 5'b11111;

  typedef enum logic {
    FETCH_IDLE,
    FETCH_BUSY
  } fetch_state_e;

  // The three 32-bit prefixes are exactly the halfwords at or above {11101, 11'b0}.
  function automatic logic is_thumb32(input logic [HW_W-1:0] hw);
    return hw >= {T32_PFX_A, 11'b0};
  endfunction

endpackage

// File: rtl/thumb_fetch_align_hw_fifo.sv
// Halfword circular buffer: pushes one (upper) or two halfwords per cycle,
// pops one or two from the head, exposes the two head entries and the fill count.
module hw_fifo
  import thumb_fetch_align_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            push1_i,
  input  logic            push2_i,
  input  logic [31:0]     din_i,
  input  logic            pop1_i,
  input  logic            pop2_i,
  output logic [CW-1:0]   count_o,
  output logic [HW_W-1:0] head0_o,
  output logic [HW_W-1:0] head1_o
);

  logic [HW_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_nx;
  logic [PW-1:0]   tail_q, tail_nx;
  logic [CW-1:0]   count_q, count_d;

  assign head_nx = head_q + PW'(1);
  assign tail_nx = tail_q + PW'(1);

  // Net occupancy change for the cycle's push and pop.
  always_comb begin
    count_d = count_q;
    if (push2_i)      count_d = count_d + CW'(2);
    else if (push1_i) count_d = count_d + CW'(1);
    if (pop2_i)       count_d = count_d - CW'(2);
    else if (pop1_i)  count_d = count_d - CW'(1);
  end

  // Pointer and count update; flush empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push2_i)      tail_q <= tail_q + PW'(2);
      else if (push1_i) tail_q <= tail_nx;
      if (pop2_i)       head_q <= head_q + PW'(2);
      else if (pop1_i)  head_q <= head_nx;
      count_q <= count_d;
    end
  end

  // Storage write; a single push carries the upper halfword of the word.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (push2_i) begin
        mem_q[tail_q]  <= din_i[15:0];
        mem_q[tail_nx] <= din_i[31:16];
      end else if (push1_i) begin
        mem_q[tail_q]  <= din_i[31:16];
      end
    end
  end

  assign count_o = count_q;
  assign head0_o = mem_q[head_q];
  assign head1_o = mem_q[head_nx];

endmodule

// File: rtl/thumb_fetch_align.sv
// Thumb-2 fetch and halfword alignment: word fetches into a halfword buffer,
// 16/32-bit instruction reassembly (including word-straddling), branch redirect.
// Optional FETCH_PERF_EN adds saturating starve/flush performance counters.
module thumb_fetch_align
  import thumb_fetch_align_pkg::*;
#(
  parameter int unsigned BUF_HW   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic        inst_is32,
  output logic [31:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_starve,
  output logic [15:0] perf_flush
`endif
);

  localparam int unsigned CW = $clog2(BUF_HW) + 1;
  localparam logic [CW-1:0] REQ_MAX = CW'(BUF_HW - 2);

  fetch_state_e    state_q;
  logic [31:0]     addr_q;
  logic [31:0]     pend_q;
  logic            drop_q;
  logic            skip_q;
  logic [31:0]     pc_q;

  logic [CW-1:0]   count;
  logic [HW_W-1:0] hw0, hw1;
  logic            head32, avail, pop, ack_take;

  assign head32   = is_thumb32(hw0);
  assign avail    = head32 ? (count >= CW'(2)) : (count >= CW'(1));
  assign pop      = inst_valid && inst_ready;
  assign ack_take = imem_req && imem_ack && !drop_q && !branch_valid;

  hw_fifo #(.DEPTH(BUF_HW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (branch_valid),
    .push1_i (ack_take && skip_q),
    .push2_i (ack_take && !skip_q),
    .din_i   (imem_rdata),
    .pop1_i  (pop && !head32),
    .pop2_i  (pop && head32),
    .count_o (count),
    .head0_o (hw0),
    .head1_o (hw1)
  );

  // Fetch FSM plus PC tracking. A branch during an unacked request keeps the
  // old address on the bus (it must stay stable) and parks the target in pend_q
  // until the stale ack has been swallowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_IDLE;
      addr_q  <= RESET_PC & ~32'h3;
      pend_q  <= RESET_PC & ~32'h3;
      drop_q  <= 1'b0;
      skip_q  <= RESET_PC[1];
      pc_q    <= RESET_PC & ~32'h1;
    end else if (branch_valid) begin
      pc_q   <= branch_target & ~32'h1;
      skip_q <= branch_target[1];
      if (state_q == FETCH_BUSY && !imem_ack) begin
        drop_q <= 1'b1;
        pend_q <= branch_target & ~32'h3;
      end else begin
        drop_q  <= 1'b0;
        state_q <= FETCH_BUSY;
        addr_q  <= branch_target & ~32'h3;
      end
    end else begin
      if (pop) pc_q <= pc_q + (head32 ? 32'd4 : 32'd2);
      case (state_q)
        FETCH_IDLE: begin
          if (count <= REQ_MAX) state_q <= FETCH_BUSY;
        end
        FETCH_BUSY: begin
          if (imem_ack) begin
            state_q <= FETCH_IDLE;
            if (drop_q) begin
              drop_q <= 1'b0;
              addr_q <= pend_q;
            end else begin
              addr_q <= addr_q + 32'd4;
              skip_q <= 1'b0;
            end
          end
        end
        default: state_q <= FETCH_IDLE;
      endcase
    end
  end

  assign imem_req   = (state_q == FETCH_BUSY);
  assign imem_addr  = addr_q;
  assign inst_pc    = pc_q;
  assign inst_valid = avail && !branch_valid;
  assign inst_is32  = (count != '0) && head32;
  assign inst       = !inst_valid ? '0 : (head32 ? {hw0, hw1} : {hw0, 16'h0000});

`ifdef FETCH_PERF_EN
  logic [31:0] starve_q;
  logic [15:0] flush_q;

  // Saturating counters for decoder starvation and branch flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      flush_q  <= '0;
    end else begin
      if (inst_ready && !inst_valid && starve_q != '1) starve_q <= starve_q + 32'd1;
      if (branch_valid && flush_q != '1)               flush_q  <= flush_q + 16'd1;
    end
  end

  assign perf_starve = starve_q;
  assign perf_flush  = flush_q;
`endif

endmodule

// File: tb/tb_thumb_fetch_align.sv
// Self-checking bench for thumb_fetch_align: directed scenarios plus a random
// phase, all checked against an instruction-stream model of a halfword memory.
module tb_thumb_fetch_align;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic        inst_is32;
  logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_starve;
  logic [15:0] perf_flush;
`endif

  always #5 clk = ~clk;

  thumb_fetch_align #(.BUF_HW(4), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_is32     (inst_is32),
    .inst_pc       (inst_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_starve   (perf_starve),
    .perf_flush    (perf_flush)
`endif
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [15:0] mem_hw [256];

  logic        rdy = 1'b0;
  logic        br_pend = 1'b0;
  logic [31:0] br_tgt = '0;
  logic        hold_en = 1'b0;
  logic [31:0] hold_addr = '0;
  int unsigned max_wait = 0;
  int unsigned wait_cnt = 0;
  logic        req_seen = 1'b0;
  logic [31:0] req_addr = '0;
  int unsigned n_acks = 0;
  int unsigned n_br = 0;
  int unsigned n_starve = 0;
  logic [31:0] m_pc = '0;

  logic [31:0] acc_inst [$];
  logic [31:0] acc_pc   [$];
  logic        acc_is32 [$];
  logic [31:0] req_log  [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    return mem_hw[8'(a >> 1)];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] i;
    i = 8'(a >> 1) & 8'hFE;
    return {mem_hw[i + 8'd1], mem_hw[i]};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    logic [7:0] i;
    i = 8'(a >> 1) & 8'hFE;
    mem_hw[i]        = w[15:0];
    mem_hw[i + 8'd1] = w[31:16];
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem_hw[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    branch_valid = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0;
    br_pend = 1'b0; req_seen = 1'b0; wait_cnt = 0;
    n_acks = 0; n_br = 0; n_starve = 0; m_pc = '0;
    acc_inst.delete(); acc_pc.delete(); acc_is32.delete(); req_log.delete();
    #1;
    check("rst_req",   32'(imem_req),   32'd0);
    check("rst_addr",  imem_addr,       32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst",  inst,            32'd0);
    check("rst_is32",  32'(inst_is32),  32'd0);
    check("rst_pc",    inst_pc,         32'd0);
`ifdef FETCH_PERF_EN
    check("rst_starve", perf_starve, 32'd0);
    check("rst_flush",  32'(perf_flush), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs at the falling edge, respond to fetches, then
  // compare the presented instruction with the memory-derived stream.
  task automatic cycle();
    logic [15:0] h0, h1;
    logic        e32;
    logic [31:0] e_inst;
    @(negedge clk);
    branch_valid  = br_pend;
    branch_target = br_tgt;
    br_pend       = 1'b0;
    inst_ready    = rdy;
    imem_ack      = 1'b0;
    imem_rdata    = '0;
    if (imem_req) begin
      if (!req_seen) begin
        req_seen = 1'b1;
        req_addr = imem_addr;
        req_log.push_back(imem_addr);
        check("addr_align", 32'(imem_addr[1:0]), 32'd0);
      end
      if (!(hold_en && imem_addr == hold_addr)) begin
        if (wait_cnt == 0) begin
          check("addr_stable", imem_addr, req_addr);
          imem_ack   = 1'b1;
          imem_rdata = word_at(imem_addr);
          req_seen   = 1'b0;
          n_acks++;
          wait_cnt = $urandom_range(0, max_wait);
        end else begin
          wait_cnt--;
        end
      end
    end
    #1;
    if (inst_ready && !inst_valid) n_starve++;
    check("pc", inst_pc, m_pc);
    if (branch_valid) begin
      check("br_valid", 32'(inst_valid), 32'd0);
      m_pc = branch_target & ~32'h1;
      n_br++;
    end else if (inst_valid) begin
      h0  = hw_at(m_pc);
      h1  = hw_at(m_pc + 32'd2);
      e32 = (h0 >> 11) >= 16'd29;
      e_inst = e32 ? {h0, h1} : {h0, 16'h0000};
      check("inst", inst, e_inst);
      check("is32", 32'(inst_is32), 32'(e32));
      if (inst_ready) begin
        acc_inst.push_back(inst);
        acc_pc.push_back(inst_pc);
        acc_is32.push_back(inst_is32);
        m_pc = m_pc + (e32 ? 32'd4 : 32'd2);
      end
    end
  endtask

  task automatic run_until_acc(input int unsigned n);
    for (int i = 0; i < 200 && acc_inst.size() < n; i++) cycle();
    check("acc_count", 32'(acc_inst.size() >= n), 32'd1);
  endtask

  initial begin
    max_wait = 0;

    // Two 16-bit instructions from one word.
    clear_mem();
    set_word(32'h0, 32'h1C08_4148);
    do_reset();
    rdy = 1'b1;
    run_until_acc(2);
    if (acc_inst.size() >= 2) begin
      check("t1_i0", acc_inst[0], 32'h4148_0000);
      check("t1_p0", acc_pc[0], 32'h0);
      check("t1_s0", 32'(acc_is32[0]), 32'd0);
      check("t1_i1", acc_inst[1], 32'h1C08_0000);
      check("t1_p1", acc_pc[1], 32'h2);
      check("t1_s1", 32'(acc_is32[1]), 32'd0);
    end

    // One aligned 32-bit instruction.
    clear_mem();
    set_word(32'h0, 32'hF000_F7FF);
    do_reset();
    rdy = 1'b1;
    run_until_acc(2);
    if (acc_inst.size() >= 2) begin
      check("t2_i0", acc_inst[0], 32'hF7FF_F000);
      check("t2_s0", 32'(acc_is32[0]), 32'd1);
      check("t2_p0", acc_pc[0], 32'h0);
      check("t2_p1", acc_pc[1], 32'h4);
    end

    // 32-bit instruction straddling a word boundary, slow memory.
    clear_mem();
    set_word(32'h0, 32'hE92D_4148);
    set_word(32'h4, 32'h1C08_4FF0);
    max_wait = 3;
    do_reset();
    rdy = 1'b1;
    run_until_acc(3);
    if (acc_inst.size() >= 3) begin
      check("t3_i0", acc_inst[0], 32'h4148_0000);
      check("t3_p0", acc_pc[0], 32'h0);
      check("t3_i1", acc_inst[1], 32'hE92D_4FF0);
      check("t3_p1", acc_pc[1], 32'h2);
      check("t3_s1", 32'(acc_is32[1]), 32'd1);
      check("t3_i2", acc_inst[2], 32'h1C08_0000);
      check("t3_p2", acc_pc[2], 32'h6);
    end
    max_wait = 0;

    // Branch to an odd halfword while the fetch of word 4 is outstanding.
    clear_mem();
    set_word(32'h0,   32'h1C08_4148);
    set_word(32'h4,   32'hAAAA_BBBB);
    set_word(32'h100, 32'h1C08_4148);
    do_reset();
    rdy = 1'b0;
    hold_en = 1'b1; hold_addr = 32'h4;
    for (int i = 0; i < 50 && !(imem_req && imem_addr == 32'h4); i++) cycle();
    check("t4_req4", 32'(imem_req && imem_addr == 32'h4), 32'd1);
    br_pend = 1'b1; br_tgt = 32'h0000_0102;
    cycle();
    hold_en = 1'b0;
    rdy = 1'b1;
    run_until_acc(1);
    if (acc_inst.size() >= 1) begin
      check("t4_i0", acc_inst[0], 32'h1C08_0000);
      check("t4_p0", acc_pc[0], 32'h102);
    end
    if (req_log.size() >= 3) check("t4_req_tgt", req_log[2], 32'h100);
    else check("t4_req_cnt", 32'(req_log.size()), 32'd3);

    // Decoder stalled: buffer fills to 4 halfwords, then drains and refetches.
    clear_mem();
    do_reset();
    rdy = 1'b0;
    repeat (20) cycle();
    check("t5_req_idle", 32'(imem_req), 32'd0);
    check("t5_acks", n_acks, 32'd2);
    check("t5_valid", 32'(inst_valid), 32'd1);
    req_log.delete();
    rdy = 1'b1;
    run_until_acc(4);
    for (int i = 0; i < 20 && req_log.size() == 0; i++) cycle();
    if (req_log.size() >= 1) check("t5_resume", req_log[0], 32'h8);
    else check("t5_resume_seen", 32'd0, 32'd1);

    // Reset asserted with a request outstanding.
    clear_mem();
    do_reset();
    hold_en = 1'b1; hold_addr = 32'h0;
    for (int i = 0; i < 10 && !imem_req; i++) cycle();
    check("t6_req", 32'(imem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_req_rst", 32'(imem_req), 32'd0);
    check("t6_valid_rst", 32'(inst_valid), 32'd0);
    @(negedge clk);
    req_seen = 1'b0; wait_cnt = 0; m_pc = '0; req_log.delete();
    hold_en = 1'b0;
    rst_n = 1'b1;
    rdy = 1'b1;
    for (int i = 0; i < 10 && req_log.size() == 0; i++) cycle();
    if (req_log.size() >= 1) check("t6_first_req", req_log[0], 32'h0);
    else check("t6_first_req_seen", 32'd0, 32'd1);

    // Random phase: mixed widths, random ready, latency and branches.
    for (int i = 0; i < 256; i++) begin
      logic [31:0] r;
      r = $urandom;
      if (r[1:0] == 2'b00) mem_hw[i] = {5'd29 + 5'(r[9:8] % 2'd3), r[26:16]};
      else                 mem_hw[i] = r[31:16];
    end
    max_wait = 3;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom % 10) < 7;
      if (!br_pend && ($urandom % 40) == 0) begin
        br_pend = 1'b1;
        br_tgt  = $urandom_range(0, 511);
      end
      cycle();
      if (($urandom % 150) == 0) begin
        br_pend = 1'b1;
        br_tgt  = $urandom_range(0, 511);
      end
    end
    check("rand_progress", 32'(acc_inst.size() > 300), 32'd1);
`ifdef FETCH_PERF_EN
    @(posedge clk);
    #1;
    check("perf_flush", 32'(perf_flush), n_br);
    check("perf_starve", perf_starve, n_starve);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
